// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues instruction-memory requests, tracks the fetch PC and
// hands each completed fetch address to the PC stage, with stall, redirect and halt.
module fetch_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = {ADDR_W{1'b0}},
    parameter int                INSTR_BYTES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] next_pc,
    output logic              pc_valid,
    output logic              flush,
    output logic [31:0]       fetch_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STALL  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0] next_pc_q, next_pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              flush_q, flush_d;
    logic [31:0]       fetch_count_q, fetch_count_d;
    logic              drop_pending_q, drop_pending_d;
    logic              halt_pending_q, halt_pending_d;

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] resume_addr;
    logic              take_branch;
    logic              post_ack;

    assign target   = {branch_target[ADDR_W-1:2], 2'b00};
    assign seq_addr = imem_addr_q + ADDR_W'(INSTR_BYTES);

    // State register; reset abandons any outstanding memory transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            fetch_pc_q     <= RESET_VECTOR;
            imem_req_q     <= 1'b0;
            imem_addr_q    <= RESET_VECTOR;
            next_pc_q      <= RESET_VECTOR;
            pc_valid_q     <= 1'b0;
            flush_q        <= 1'b0;
            fetch_count_q  <= 32'd0;
            drop_pending_q <= 1'b0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            imem_req_q     <= imem_req_d;
            imem_addr_q    <= imem_addr_d;
            next_pc_q      <= next_pc_d;
            pc_valid_q     <= pc_valid_d;
            flush_q        <= flush_d;
            fetch_count_q  <= fetch_count_d;
            drop_pending_q <= drop_pending_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        imem_req_d     = imem_req_q;
        imem_addr_d    = imem_addr_q;
        next_pc_d      = next_pc_q;
        pc_valid_d     = 1'b0;
        flush_d        = 1'b0;
        fetch_count_d  = fetch_count_q;
        drop_pending_d = drop_pending_q;
        halt_pending_d = halt_pending_q;
        resume_addr    = fetch_pc_q;
        post_ack       = 1'b0;
        // A redirect racing a halt is dropped so the halt point stays well defined.
        take_branch    = branch_valid && !halt_pending_q && !halt;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d    = HALTED;
                    imem_req_d = 1'b0;
                end else if (stall) begin
                    state_d    = STALL;
                    imem_req_d = 1'b0;
                end else begin
                    state_d     = FETCH;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                end
            end
            FETCH: begin
                if (take_branch) begin
                    fetch_pc_d = target;
                    flush_d    = 1'b1;
                    if (imem_ack) begin
                        drop_pending_d = 1'b0;
                        post_ack       = 1'b1;
                        resume_addr    = target;
                    end else begin
                        drop_pending_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    post_ack = 1'b1;
                    if (drop_pending_q) begin
                        drop_pending_d = 1'b0;
                        resume_addr    = fetch_pc_q;
                    end else begin
                        next_pc_d     = imem_addr_q;
                        pc_valid_d    = 1'b1;
                        fetch_count_d = fetch_count_q + 32'd1;
                        fetch_pc_d    = seq_addr;
                        resume_addr   = seq_addr;
                    end
                end else if (halt) begin
                    halt_pending_d = 1'b1;
                end else begin
                    halt_pending_d = halt_pending_q;
                end

                if (post_ack) begin
                    if (halt || halt_pending_q) begin
                        state_d        = HALTED;
                        imem_req_d     = 1'b0;
                        halt_pending_d = 1'b0;
                    end else if (stall) begin
                        state_d    = STALL;
                        imem_req_d = 1'b0;
                    end else begin
                        imem_req_d  = 1'b1;
                        imem_addr_d = resume_addr;
                    end
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            STALL: begin
                imem_req_d = 1'b0;
                if (halt) begin
                    state_d = HALTED;
                end else if (branch_valid) begin
                    fetch_pc_d = target;
                    flush_d    = 1'b1;
                end else if (!stall) begin
                    state_d     = FETCH;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                end else begin
                    state_d = STALL;
                end
            end
            HALTED: begin
                imem_req_d = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign next_pc     = next_pc_q;
    assign pc_valid    = pc_valid_q;
    assign flush       = flush_q;
    assign fetch_count = fetch_count_q;
    assign state       = state_q;

endmodule
